// File: rtl/csr_core.sv
// LoongArch CSR file with exception/ERTN commit, interrupt masking and a countdown timer.
// Latency: reads combinational, writes/commits visible next cycle; no backpressure, every request is accepted.
module csr_core #(
    parameter int          SAVE_NUM = 4,
    parameter int          TIMER_W  = 32,
    parameter logic [31:0] TID_RST  = 32'h0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rdata,
    input  logic        csr_we,
    input  logic [31:0] csr_wdata,
    input  logic [31:0] csr_wmask,
    input  logic        exc_valid,
    input  logic [5:0]  exc_ecode,
    input  logic [8:0]  exc_esubcode,
    input  logic [31:0] exc_pc,
    input  logic        exc_badv_we,
    input  logic [31:0] exc_badv,
    input  logic        ertn_valid,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic [31:0] exc_entry_pc,
    output logic [31:0] ertn_pc,
    output logic        has_int
);

    localparam logic [13:0] CSR_CRMD   = 14'h0;
    localparam logic [13:0] CSR_PRMD   = 14'h1;
    localparam logic [13:0] CSR_ECFG   = 14'h4;
    localparam logic [13:0] CSR_ESTAT  = 14'h5;
    localparam logic [13:0] CSR_ERA    = 14'h6;
    localparam logic [13:0] CSR_BADV   = 14'h7;
    localparam logic [13:0] CSR_EENTRY = 14'hC;
    localparam logic [13:0] CSR_SAVE0  = 14'h30;
    localparam logic [13:0] CSR_TID    = 14'h40;
    localparam logic [13:0] CSR_TCFG   = 14'h41;
    localparam logic [13:0] CSR_TVAL   = 14'h42;
    localparam logic [13:0] CSR_TICLR  = 14'h44;

    logic [8:0]         crmd_q, crmd_d;
    logic [2:0]         prmd_q, prmd_d;
    logic [12:0]        ecfg_q, ecfg_d;
    logic [1:0]         is_sw_q, is_sw_d;
    logic [7:0]         hw_int_q, hw_int_d;
    logic               ipi_q, ipi_d;
    logic               ti_q, ti_d;
    logic [5:0]         ecode_q, ecode_d;
    logic [8:0]         esubcode_q, esubcode_d;
    logic [31:0]        era_q, era_d;
    logic [31:0]        badv_q, badv_d;
    logic [25:0]        eentry_q, eentry_d;
    logic [31:0]        save_q [SAVE_NUM];
    logic [31:0]        save_d [SAVE_NUM];
    logic [31:0]        tid_q, tid_d;
    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] cnt_q, cnt_d;
    logic               active_q, active_d;

    logic [12:0] estat_is;
    logic [31:0] wr_val;
    logic        timer_expire;

    assign estat_is     = {ipi_q, ti_q, 1'b0, hw_int_q, is_sw_q};
    assign timer_expire = active_q && (cnt_q == '0);
    // Old value comes from the read port, so one merge serves every register.
    assign wr_val       = (csr_wmask & csr_wdata) | (~csr_wmask & csr_rdata);

    assign exc_entry_pc = {eentry_q, 6'b0};
    assign ertn_pc      = era_q;
    assign has_int      = crmd_q[2] & (|(ecfg_q & estat_is));

    always_comb begin
        csr_rdata = '0;
        case (csr_num)
            CSR_CRMD:   csr_rdata = {23'b0, crmd_q};
            CSR_PRMD:   csr_rdata = {29'b0, prmd_q};
            CSR_ECFG:   csr_rdata = {19'b0, ecfg_q};
            CSR_ESTAT:  csr_rdata = {1'b0, esubcode_q, ecode_q, 3'b0, estat_is};
            CSR_ERA:    csr_rdata = era_q;
            CSR_BADV:   csr_rdata = badv_q;
            CSR_EENTRY: csr_rdata = {eentry_q, 6'b0};
            CSR_TID:    csr_rdata = tid_q;
            CSR_TCFG:   csr_rdata = 32'(tcfg_q);
            CSR_TVAL:   csr_rdata = 32'(cnt_q);
            default: begin
                for (int i = 0; i < SAVE_NUM; i++) begin
                    if (csr_num == CSR_SAVE0 + 14'(i)) csr_rdata = save_q[i];
                end
            end
        endcase
    end

    always_comb begin
        crmd_d     = crmd_q;
        prmd_d     = prmd_q;
        ecfg_d     = ecfg_q;
        is_sw_d    = is_sw_q;
        hw_int_d   = hw_int_in;
        ipi_d      = ipi_int_in;
        ti_d       = ti_q;
        ecode_d    = ecode_q;
        esubcode_d = esubcode_q;
        era_d      = era_q;
        badv_d     = badv_q;
        eentry_d   = eentry_q;
        save_d     = save_q;
        tid_d      = tid_q;
        tcfg_d     = tcfg_q;
        cnt_d      = cnt_q;
        active_d   = active_q;

        if (active_q) begin
            if (cnt_q != '0)     cnt_d = cnt_q - TIMER_W'(1);
            else if (tcfg_q[1])  cnt_d = {tcfg_q[TIMER_W-1:2], 2'b00};
            else                 active_d = 1'b0;
        end

        if (exc_valid) begin
            prmd_d      = crmd_q[2:0];
            crmd_d[2:0] = 3'b000;
            ecode_d     = exc_ecode;
            esubcode_d  = exc_esubcode;
            era_d       = exc_pc;
            if (exc_badv_we) badv_d = exc_badv;
        end else if (ertn_valid) begin
            crmd_d[2:0] = prmd_q;
        end else if (csr_we) begin
            case (csr_num)
                CSR_CRMD:   crmd_d   = wr_val[8:0];
                CSR_PRMD:   prmd_d   = wr_val[2:0];
                CSR_ECFG:   ecfg_d   = wr_val[12:0] & 13'h1BFF;
                CSR_ESTAT:  is_sw_d  = wr_val[1:0];
                CSR_ERA:    era_d    = wr_val;
                CSR_BADV:   badv_d   = wr_val;
                CSR_EENTRY: eentry_d = wr_val[31:6];
                CSR_TID:    tid_d    = wr_val;
                CSR_TCFG: begin
                    // A TCFG write overrides whatever the countdown did this cycle.
                    tcfg_d   = wr_val[TIMER_W-1:0];
                    active_d = wr_val[0];
                    cnt_d    = wr_val[0] ? {wr_val[TIMER_W-1:2], 2'b00} : cnt_q;
                end
                CSR_TICLR: begin
                    if (wr_val[0]) ti_d = 1'b0;
                end
                default: begin
                    for (int i = 0; i < SAVE_NUM; i++) begin
                        if (csr_num == CSR_SAVE0 + 14'(i)) save_d[i] = wr_val;
                    end
                end
            endcase
        end

        if (timer_expire) ti_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            crmd_q     <= 9'h008;
            prmd_q     <= '0;
            ecfg_q     <= '0;
            is_sw_q    <= '0;
            hw_int_q   <= '0;
            ipi_q      <= 1'b0;
            ti_q       <= 1'b0;
            ecode_q    <= '0;
            esubcode_q <= '0;
            era_q      <= '0;
            badv_q     <= '0;
            eentry_q   <= '0;
            for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
            tid_q      <= TID_RST;
            tcfg_q     <= '0;
            cnt_q      <= '0;
            active_q   <= 1'b0;
        end else begin
            crmd_q     <= crmd_d;
            prmd_q     <= prmd_d;
            ecfg_q     <= ecfg_d;
            is_sw_q    <= is_sw_d;
            hw_int_q   <= hw_int_d;
            ipi_q      <= ipi_d;
            ti_q       <= ti_d;
            ecode_q    <= ecode_d;
            esubcode_q <= esubcode_d;
            era_q      <= era_d;
            badv_q     <= badv_d;
            eentry_q   <= eentry_d;
            save_q     <= save_d;
            tid_q      <= tid_d;
            tcfg_q     <= tcfg_d;
            cnt_q      <= cnt_d;
            active_q   <= active_d;
        end
    end

endmodule

// File: tb/tb_csr_core.sv
// Directed bench for csr_core: expectations are queued as each step is driven and popped when the output is sampled.
module tb_csr_core;

    logic        clk = 1'b0;
    logic        resetn;
    logic [13:0] csr_num;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [31:0] csr_wdata, csr_wmask;
    logic        exc_valid;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;
    logic [31:0] exc_pc;
    logic        exc_badv_we;
    logic [31:0] exc_badv;
    logic        ertn_valid;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic [31:0] exc_entry_pc, ertn_pc;
    logic        has_int;

    localparam logic [31:0] TIDV = 32'h1234_5678;
    localparam logic [31:0] E0   = 32'h7FC1_0000;
    localparam logic [31:0] ETI  = 32'h7FC1_0800;

    csr_core #(.SAVE_NUM(2), .TIMER_W(32), .TID_RST(TIDV)) dut (
        .clk(clk), .resetn(resetn), .csr_num(csr_num), .csr_rdata(csr_rdata),
        .csr_we(csr_we), .csr_wdata(csr_wdata), .csr_wmask(csr_wmask),
        .exc_valid(exc_valid), .exc_ecode(exc_ecode), .exc_esubcode(exc_esubcode),
        .exc_pc(exc_pc), .exc_badv_we(exc_badv_we), .exc_badv(exc_badv),
        .ertn_valid(ertn_valid), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .exc_entry_pc(exc_entry_pc), .ertn_pc(ertn_pc), .has_int(has_int)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic cmp(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed %h with nothing queued", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] e, input string tag);
        csr_num = a;
        push(tag, e);
        #2;
        cmp(csr_rdata);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        push(tag, e);
        cmp(obs);
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        csr_num   = a;
        csr_wdata = d;
        csr_wmask = m;
        csr_we    = 1'b1;
        nxt();
        csr_we    = 1'b0;
    endtask

    logic [13:0] rst_addr [14] = '{14'h0, 14'h1, 14'h4, 14'h5, 14'h6, 14'h7, 14'hC,
                                   14'h30, 14'h31, 14'h40, 14'h41, 14'h42, 14'h44, 14'h3};
    logic [31:0] rst_exp  [14] = '{32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                   32'h0, 32'h0, TIDV, 32'h0, 32'h0, 32'h0, 32'h0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, limit 100000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; csr_num = '0; csr_we = 1'b0; csr_wdata = '0; csr_wmask = '0;
        exc_valid = 1'b0; exc_ecode = '0; exc_esubcode = '0; exc_pc = '0;
        exc_badv_we = 1'b0; exc_badv = '0; ertn_valid = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
        repeat (3) nxt();
        resetn = 1'b1;

        chk("rst_has_int", 32'(has_int), 32'h0);
        chk("rst_exc_entry_pc", exc_entry_pc, 32'h0);
        chk("rst_ertn_pc", ertn_pc, 32'h0);
        for (int i = 0; i < 14; i++) begin
            rd(rst_addr[i], rst_exp[i], $sformatf("rst_rd_%h", rst_addr[i]));
            nxt();
        end

        // Exception commit and return
        wr(14'hC, 32'h1C00_8000, 32'hFFFF_FFFF);
        rd(14'hC, 32'h1C00_8000, "eentry_rd");
        chk("exc_entry_pc", exc_entry_pc, 32'h1C00_8000);
        wr(14'h0, 32'h7, 32'h7);
        rd(14'h0, 32'hF, "crmd_masked_wr");
        exc_valid = 1'b1; exc_ecode = 6'h0B; exc_esubcode = 9'h0; exc_pc = 32'h1C00_0100;
        exc_badv_we = 1'b1; exc_badv = 32'h0000_1234;
        nxt();
        exc_valid = 1'b0; exc_badv_we = 1'b0;
        rd(14'h0, 32'h8, "exc_crmd");
        rd(14'h1, 32'h7, "exc_prmd");
        rd(14'h6, 32'h1C00_0100, "exc_era");
        nxt();
        rd(14'h5, 32'h000B_0000, "exc_estat");
        rd(14'h7, 32'h0000_1234, "exc_badv");
        chk("ertn_pc", ertn_pc, 32'h1C00_0100);
        ertn_valid = 1'b1;
        nxt();
        ertn_valid = 1'b0;
        rd(14'h0, 32'hF, "ertn_crmd");

        // Exception beats ERTN and a CSR write in the same cycle
        exc_valid = 1'b1; ertn_valid = 1'b1; exc_ecode = 6'h01; exc_esubcode = 9'h1FF;
        exc_pc = 32'h1C00_0200;
        csr_num = 14'h6; csr_wdata = 32'hDEAD_BEEF; csr_wmask = 32'hFFFF_FFFF; csr_we = 1'b1;
        nxt();
        exc_valid = 1'b0; ertn_valid = 1'b0; csr_we = 1'b0;
        rd(14'h6, 32'h1C00_0200, "prio_era");
        rd(14'h0, 32'h8, "prio_crmd");
        rd(14'h5, E0, "prio_estat");
        nxt();
        rd(14'h7, 32'h0000_1234, "prio_badv_kept");

        // Read-only / reserved fields
        wr(14'h5, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h5, E0 | 32'h3, "estat_sw_only");
        wr(14'h5, 32'h0, 32'h3);
        rd(14'h5, E0, "estat_sw_clr");
        wr(14'h4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd(14'h4, 32'h1BFF, "ecfg_fields");

        // Interrupt sampling and masking
        wr(14'h0, 32'h4, 32'h4);
        wr(14'h4, 32'h4, 32'hFFFF_FFFF);
        hw_int_in = 8'h01;
        chk("hwint_same_cycle", 32'(has_int), 32'h0);
        nxt();
        chk("hwint_next_cycle", 32'(has_int), 32'h1);
        rd(14'h5, E0 | 32'h4, "estat_hwint");
        wr(14'h4, 32'h0, 32'hFFFF_FFFF);
        chk("hwint_masked", 32'(has_int), 32'h0);
        hw_int_in = 8'h00;
        wr(14'h4, 32'h1000, 32'hFFFF_FFFF);
        ipi_int_in = 1'b1;
        nxt();
        chk("ipi_int", 32'(has_int), 32'h1);
        ipi_int_in = 1'b0;
        nxt();
        chk("ipi_drop", 32'(has_int), 32'h0);
        wr(14'h4, 32'h800, 32'hFFFF_FFFF);

        // One-shot timer, L=16
        wr(14'h41, 32'h11, 32'hFFFF_FFFF);
        for (int k = 1; k <= 17; k++) begin
            rd(14'h42, 32'(17 - k), $sformatf("oneshot_tval_t%0d", k));
            chk($sformatf("oneshot_noint_t%0d", k), 32'(has_int), 32'h0);
            nxt();
        end
        rd(14'h5, ETI, "oneshot_ti");
        chk("oneshot_has_int", 32'(has_int), 32'h1);
        repeat (5) nxt();
        rd(14'h42, 32'h0, "oneshot_tval_hold");
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        rd(14'h5, E0, "ticlr_clears");
        chk("ticlr_has_int", 32'(has_int), 32'h0);
        rd(14'h44, 32'h0, "ticlr_reads0");
        repeat (20) nxt();
        rd(14'h5, E0, "oneshot_no_retrigger");

        // Periodic timer, L=16, period 17
        wr(14'h41, 32'h13, 32'hFFFF_FFFF);
        rd(14'h42, 32'd16, "per_tval_load");
        repeat (16) nxt();
        rd(14'h42, 32'h0, "per_tval_zero");
        rd(14'h5, E0, "per_ti_not_yet");
        nxt();
        rd(14'h5, ETI, "per_ti_first");
        rd(14'h42, 32'd16, "per_reload");
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        rd(14'h5, E0, "per_ticlr");
        rd(14'h42, 32'd15, "per_count");
        repeat (15) nxt();
        rd(14'h42, 32'h0, "per_tval_zero2");
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        rd(14'h5, ETI, "ticlr_vs_expiry");
        rd(14'h42, 32'd16, "per_reload2");
        wr(14'h44, 32'h1, 32'hFFFF_FFFF);
        rd(14'h5, E0, "per_ticlr2");
        repeat (15) nxt();
        wr(14'h41, 32'h09, 32'hFFFF_FFFF);
        rd(14'h42, 32'd8, "tcfg_wr_at_expiry_cnt");
        rd(14'h5, ETI, "tcfg_wr_at_expiry_ti");
        wr(14'h41, 32'h0, 32'hFFFF_FFFF);
        repeat (3) nxt();
        rd(14'h42, 32'd8, "tcfg_disable_holds");
        rd(14'h41, 32'h0, "tcfg_rd");

        // Reset while counting
        wr(14'h41, 32'h09, 32'hFFFF_FFFF);
        repeat (3) nxt();
        resetn = 1'b0;
        nxt();
        resetn = 1'b1;
        rd(14'h42, 32'h0, "rst_mid_tval");
        rd(14'h41, 32'h0, "rst_mid_tcfg");
        repeat (12) nxt();
        rd(14'h5, 32'h0, "rst_mid_no_ti");
        rd(14'h0, 32'h8, "rst_mid_crmd");

        // SAVE bank with SAVE_NUM=2
        wr(14'h31, 32'hA5A5_0F0F, 32'hFFFF_FFFF);
        rd(14'h31, 32'hA5A5_0F0F, "save1_rd");
        wr(14'h31, 32'hFFFF_FFFF, 32'h0000_FF00);
        rd(14'h31, 32'hA5A5_FF0F, "save1_masked");
        wr(14'h32, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        rd(14'h32, 32'h0, "save2_unmapped");
        rd(14'h30, 32'h0, "save0_untouched");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
